accel_spi_responder: RTL and testbench
======================================

Name: accel_spi_responder

Overview:
- SPI mode-0 responder (slave) that emulates the ADXL362-class accelerometer register interface on the board's accelerometer pins.
- It is the far end of the accelerometer SPI master. Uses: loopback bring-up of the master, and driving game logic from synthetic X/Y/Z values fed by switches or a test bench.
- Oversamples the SPI pins in the system clock domain. Decodes register read (0x0B) and register write (0x0A) commands and returns a small register file with address auto-increment.

Parameters:
- SYNC_STAGES, 2, synchroniser depth on csn/sclk/mosi (minimum 2).
- DEVID_AD, 8'hAD, value returned at address 0x00.
- DEVID_MST, 8'h1D, value returned at address 0x01.
- PARTID, 8'hF2, value returned at address 0x02.

Ports:
- clk  in  1  system clock; must be ≥ 8× SCLK frequency.
- rst  in  1  synchronous, active-high reset.
- spi_csn_i  in  1  chip select, active low, asynchronous to clk.
- spi_sclk_i  in  1  serial clock, idle low, asynchronous.
- spi_mosi_i  in  1  master-out data, asynchronous.
- spi_miso_o  out  1  slave-out data.
- spi_miso_oe  out  1  high while selected; top level tristates MISO when low.
- accel_x_i  in  8  X value served at 0x08.
- accel_y_i  in  8  Y value served at 0x09.
- accel_z_i  in  8  Z value served at 0x0A.
- power_ctl_o  out  8  POWER_CTL register (0x2D).
- txn_done_o  out  1  one-cycle pulse when CS deasserts after an active transaction.
- cmd_err_o  out  1  one-cycle pulse when an unsupported command byte completes.

Behaviour:
Clock and reset:
- One clock, `clk`. Reset is synchronous and active-high (`rst`).
- Reset values: spi_miso_o=0, spi_miso_oe=0, power_ctl_o=8'h00, txn_done_o=0, cmd_err_o=0, state=IDLE, bit counter=0, address pointer=0.

Input synchronisation:
- csn, sclk and mosi each pass through SYNC_STAGES flops.
- Edges are detected on the synchronised signals by comparing with a one-cycle delayed copy.
- Pin-to-internal-event latency is SYNC_STAGES+1 clk cycles. MISO updates 1 clk after the detected SCLK falling edge.

SPI framing (mode 0):
- MOSI is sampled on the SCLK rising edge, MSB first.
- MISO changes on the SCLK falling edge.
- A 3-bit counter counts rising edges; a byte is complete on the 8th.

State machine:
- IDLE: CS fall → CMD. Snapshot accel_x/y/z into shadow registers; reads during this frame return the snapshot. Bit counter=0, spi_miso_oe=1.
- CMD: on byte complete:
  - 0x0B → ADDR_RD.
  - 0x0A → ADDR_WR.
  - Any other value → IGNORE, and pulse cmd_err_o.
- ADDR_RD / ADDR_WR: on byte complete, pointer ← byte[5:0] (bits [7:6] ignored). Then go to READ or WRITE.
- READ:
  - On each SCLK falling edge where the bit counter is 0 (byte boundary): tx_shift ← reg[pointer], then pointer ← pointer+1.
  - On all other falling edges: tx_shift shifts left, filling with 0.
  - spi_miso_o = tx_shift[7].
- WRITE: on each byte complete, write reg[pointer] if writable, then pointer+1.
  - 0x2D: power_ctl_o ← byte.
  - 0x1F: if byte==8'h52, power_ctl_o ← 8'h00 (soft reset); other values are ignored.
  - All other addresses are read-only; writes to them are silently dropped.
- IGNORE: MOSI is discarded and MISO is held at 0 until CS rises.

Register map (reads):
- 0x00 DEVID_AD, 0x01 DEVID_MST, 0x02 PARTID.
- 0x08 X, 0x09 Y, 0x0A Z (snapshot values).
- 0x2D POWER_CTL.
- All other addresses read 8'h00.
- The pointer wraps 0x3F→0x00.

CS rise (any non-IDLE state):
- Go to IDLE. A partial byte is discarded and not written.
- spi_miso_oe=0, spi_miso_o=0, bit counter=0.
- Pulse txn_done_o for one cycle.

Simultaneous events and reset:
- CS rise has priority over an SCLK edge detected in the same cycle.
- SCLK edges while CS is high are ignored.
- rst during a frame forces IDLE. If CS is still low when rst releases, go to IGNORE (not CMD) until CS rises; no txn_done_o pulse for that frame.
- A new CS fall one cycle after a CS rise is legal and starts a new frame.

Test Plan:
1. Read DEVID: CS low, send 0x0B,0x00, clock 3 bytes → MISO returns 0xAD,0x1D,0xF2; txn_done_o pulses once after CS high.
2. Read XYZ burst with accel_x/y/z=0x12/0x34/0x56; change inputs to 0xFF mid-frame → MISO returns 0x12,0x34,0x56 (snapshot holds).
3. Write 0x0A,0x2D,0x02 → power_ctl_o=0x02. Then write 0x0A,0x1F,0x52 → power_ctl_o=0x00. Then write 0x0A,0x1F,0x11 → power_ctl_o unchanged.
4. Command 0x0D followed by 2 bytes → cmd_err_o pulses once, MISO stays 0, no register changes, txn_done_o pulses at CS rise.
5. Read from 0x3F for 2 bytes → returns 0x00 then 0xAD (wrap to 0x00). Write 0x0A,0x2D then 4 data bits, then CS high → power_ctl_o unchanged.
6. Assert rst for 1 cycle mid-read while CS stays low → all outputs at reset values, no response until CS rises. The next frame reads DEVID correctly.

Source files
------------

// File: rtl/accel_spi_responder.sv
// rtl/accel_spi_responder.sv - SPI mode-0 responder emulating an ADXL362-class accelerometer register file
module accel_spi_responder #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] DEVID_AD    = 8'hAD,
    parameter logic [7:0] DEVID_MST   = 8'h1D,
    parameter logic [7:0] PARTID      = 8'hF2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_csn_i,
    input  logic       spi_sclk_i,
    input  logic       spi_mosi_i,
    output logic       spi_miso_o,
    output logic       spi_miso_oe,
    input  logic [7:0] accel_x_i,
    input  logic [7:0] accel_y_i,
    input  logic [7:0] accel_z_i,
    output logic [7:0] power_ctl_o,
    output logic       txn_done_o,
    output logic       cmd_err_o
);

    // A single-flop synchroniser is never acceptable, so clamp the depth at two.
    localparam int SN = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    localparam logic [7:0] CMD_WRITE = 8'h0A;
    localparam logic [7:0] CMD_READ  = 8'h0B;
    localparam logic [5:0] ADDR_SOFT_RESET = 6'h1F;
    localparam logic [5:0] ADDR_POWER_CTL  = 6'h2D;
    localparam logic [7:0] SOFT_RESET_KEY  = 8'h52;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR_RD,
        ST_ADDR_WR,
        ST_READ,
        ST_WRITE,
        ST_IGNORE
    } state_t;

    // Pin synchronisers and edge-detect history
    logic [SN-1:0] csn_sync_q, csn_sync_d;
    logic [SN-1:0] sclk_sync_q, sclk_sync_d;
    logic [SN-1:0] mosi_sync_q, mosi_sync_d;
    logic          csn_prev_q, csn_prev_d;
    logic          sclk_prev_q, sclk_prev_d;

    logic csn_s, sclk_s, mosi_s;
    logic csn_fall, csn_rise, sclk_rise, sclk_fall;

    // Protocol state
    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] tx_q, tx_d;
    logic [5:0] ptr_q, ptr_d;
    logic       oe_q, oe_d;
    logic [7:0] power_q, power_d;
    logic [7:0] shadow_x_q, shadow_x_d;
    logic [7:0] shadow_y_q, shadow_y_d;
    logic [7:0] shadow_z_q, shadow_z_d;
    logic       frame_q, frame_d;
    logic       txn_done_q, txn_done_d;
    logic       cmd_err_q, cmd_err_d;

    logic [7:0] rx_byte;
    logic       byte_done;
    logic [7:0] rd_data;

    // Shift raw pins into the synchroniser chains and keep a one-cycle-old copy for edge detection
    always_comb begin
        csn_sync_d  = {csn_sync_q[SN-2:0], spi_csn_i};
        sclk_sync_d = {sclk_sync_q[SN-2:0], spi_sclk_i};
        mosi_sync_d = {mosi_sync_q[SN-2:0], spi_mosi_i};
        csn_prev_d  = csn_sync_q[SN-1];
        sclk_prev_d = sclk_sync_q[SN-1];
    end

    // Synchronisers keep sampling through reset so a frame already in progress shows up as
    // a held-low chip select afterwards instead of a fresh falling edge
    always_ff @(posedge clk) begin
        csn_sync_q  <= csn_sync_d;
        sclk_sync_q <= sclk_sync_d;
        mosi_sync_q <= mosi_sync_d;
        csn_prev_q  <= csn_prev_d;
        sclk_prev_q <= sclk_prev_d;
    end

    assign csn_s     = csn_sync_q[SN-1];
    assign sclk_s    = sclk_sync_q[SN-1];
    assign mosi_s    = mosi_sync_q[SN-1];
    assign csn_fall  = csn_prev_q & ~csn_s;
    assign csn_rise  = ~csn_prev_q & csn_s;
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;

    assign rx_byte   = {rx_q[6:0], mosi_s};
    assign byte_done = sclk_rise && (bit_cnt_q == 3'd7);

    // Register map as seen by a read burst; XYZ come from the per-frame snapshot
    always_comb begin
        rd_data = 8'h00;
        case (ptr_q)
            6'h00:          rd_data = DEVID_AD;
            6'h01:          rd_data = DEVID_MST;
            6'h02:          rd_data = PARTID;
            6'h08:          rd_data = shadow_x_q;
            6'h09:          rd_data = shadow_y_q;
            6'h0A:          rd_data = shadow_z_q;
            ADDR_POWER_CTL: rd_data = power_q;
            default:        rd_data = 8'h00;
        endcase
    end

    // Frame state machine: next state, shift registers, pointer and register writes
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_d       = rx_q;
        tx_d       = tx_q;
        ptr_d      = ptr_q;
        oe_d       = oe_q;
        power_d    = power_q;
        shadow_x_d = shadow_x_q;
        shadow_y_d = shadow_y_q;
        shadow_z_d = shadow_z_q;
        frame_d    = frame_q;
        txn_done_d = 1'b0;
        cmd_err_d  = 1'b0;

        if (state_q == ST_IDLE) begin
            if (csn_fall) begin
                state_d    = ST_CMD;
                bit_cnt_d  = 3'd0;
                rx_d       = 8'h00;
                tx_d       = 8'h00;
                oe_d       = 1'b1;
                frame_d    = 1'b1;
                shadow_x_d = accel_x_i;
                shadow_y_d = accel_y_i;
                shadow_z_d = accel_z_i;
            end else if (!csn_s) begin
                // Chip select already low without a seen edge: the frame began before reset
                // released, so sit it out without driving MISO.
                state_d = ST_IGNORE;
            end
        end else if (csn_rise) begin
            // Chip select rising wins over any SCLK edge; a partial byte is simply dropped.
            state_d    = ST_IDLE;
            bit_cnt_d  = 3'd0;
            tx_d       = 8'h00;
            oe_d       = 1'b0;
            txn_done_d = frame_q;
            frame_d    = 1'b0;
        end else begin
            if (sclk_rise) begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                rx_d      = rx_byte;
            end
            case (state_q)
                ST_CMD: begin
                    if (byte_done) begin
                        if (rx_byte == CMD_READ) begin
                            state_d = ST_ADDR_RD;
                        end else if (rx_byte == CMD_WRITE) begin
                            state_d = ST_ADDR_WR;
                        end else begin
                            state_d   = ST_IGNORE;
                            cmd_err_d = 1'b1;
                        end
                    end
                end
                ST_ADDR_RD: begin
                    if (byte_done) begin
                        ptr_d   = rx_byte[5:0];
                        state_d = ST_READ;
                    end
                end
                ST_ADDR_WR: begin
                    if (byte_done) begin
                        ptr_d   = rx_byte[5:0];
                        state_d = ST_WRITE;
                    end
                end
                ST_READ: begin
                    if (sclk_fall) begin
                        if (bit_cnt_q == 3'd0) begin
                            tx_d  = rd_data;
                            ptr_d = ptr_q + 6'd1;
                        end else begin
                            tx_d = {tx_q[6:0], 1'b0};
                        end
                    end
                end
                ST_WRITE: begin
                    if (byte_done) begin
                        if (ptr_q == ADDR_POWER_CTL) begin
                            power_d = rx_byte;
                        end else if (ptr_q == ADDR_SOFT_RESET && rx_byte == SOFT_RESET_KEY) begin
                            power_d = 8'h00;
                        end
                        ptr_d = ptr_q + 6'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd0;
            rx_q       <= 8'h00;
            tx_q       <= 8'h00;
            ptr_q      <= 6'd0;
            oe_q       <= 1'b0;
            power_q    <= 8'h00;
            shadow_x_q <= 8'h00;
            shadow_y_q <= 8'h00;
            shadow_z_q <= 8'h00;
            frame_q    <= 1'b0;
            txn_done_q <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_q       <= rx_d;
            tx_q       <= tx_d;
            ptr_q      <= ptr_d;
            oe_q       <= oe_d;
            power_q    <= power_d;
            shadow_x_q <= shadow_x_d;
            shadow_y_q <= shadow_y_d;
            shadow_z_q <= shadow_z_d;
            frame_q    <= frame_d;
            txn_done_q <= txn_done_d;
            cmd_err_q  <= cmd_err_d;
        end
    end

    assign spi_miso_o  = tx_q[7];
    assign spi_miso_oe = oe_q;
    assign power_ctl_o = power_q;
    assign txn_done_o  = txn_done_q;
    assign cmd_err_o   = cmd_err_q;

endmodule

// File: tb/tb_accel_spi_responder.sv
// tb/tb_accel_spi_responder.sv - randomized self-checking bench for accel_spi_responder
module tb_accel_spi_responder;

    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       csn, sclk, mosi;
    logic       miso, oe;
    logic [7:0] ax, ay, az;
    logic [7:0] power;
    logic       txn_done, cmd_err;

    int n_checks = 0;
    int n_pass   = 0;
    int txn_cnt  = 0;
    int err_cnt  = 0;

    logic [7:0] m_power = 8'h00;
    logic [7:0] snap_x = 8'h00, snap_y = 8'h00, snap_z = 8'h00;

    always #5 clk = ~clk;

    accel_spi_responder dut (
        .clk         (clk),
        .rst         (rst),
        .spi_csn_i   (csn),
        .spi_sclk_i  (sclk),
        .spi_mosi_i  (mosi),
        .spi_miso_o  (miso),
        .spi_miso_oe (oe),
        .accel_x_i   (ax),
        .accel_y_i   (ay),
        .accel_z_i   (az),
        .power_ctl_o (power),
        .txn_done_o  (txn_done),
        .cmd_err_o   (cmd_err)
    );

    always @(negedge clk) begin
        if (txn_done) txn_cnt++;
        if (cmd_err) err_cnt++;
    end

    function automatic logic [7:0] model_reg(input logic [5:0] a);
        case (a)
            6'h00:   return 8'hAD;
            6'h01:   return 8'h1D;
            6'h02:   return 8'hF2;
            6'h08:   return snap_x;
            6'h09:   return snap_y;
            6'h0A:   return snap_z;
            6'h2D:   return m_power;
            default: return 8'h00;
        endcase
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_assert();
        csn = 1'b0;
        snap_x = ax;
        snap_y = ay;
        snap_z = az;
        wait_clk(HALF);
    endtask

    task automatic cs_release();
        wait_clk(4);
        csn = 1'b1;
        wait_clk(12);
    endtask

    task automatic spi_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            wait_clk(HALF);
            rx = {rx[6:0], miso};
            sclk = 1'b1;
            wait_clk(HALF);
            sclk = 1'b0;
        end
    endtask

    task automatic read_burst(input string name, input logic [5:0] addr, input int n, input bit scramble);
        logic [7:0] r;
        logic [5:0] a;
        int t0, e0;
        t0 = txn_cnt;
        e0 = err_cnt;
        cs_assert();
        spi_byte(8'h0B, 8, r);
        spi_byte({2'($urandom), addr}, 8, r);
        a = addr;
        for (int i = 0; i < n; i++) begin
            spi_byte(8'($urandom), 8, r);
            n_checks++;
            if (r !== model_reg(a)) $display("FAIL %s byte%0d @%02h: got %02h expected %02h", name, i, a, r, model_reg(a));
            else n_pass++;
            a = a + 6'd1;
            if (scramble && i == 0) begin
                ax = 8'hFF;
                ay = 8'hFF;
                az = 8'hFF;
            end
        end
        cs_release();
        n_checks++;
        if (txn_cnt - t0 !== 1) $display("FAIL %s txn_done count: got %0d expected 1", name, txn_cnt - t0);
        else n_pass++;
        n_checks++;
        if (err_cnt - e0 !== 0) $display("FAIL %s cmd_err count: got %0d expected 0", name, err_cnt - e0);
        else n_pass++;
    endtask

    task automatic write_burst(input string name, input logic [5:0] addr, input logic [7:0] d [4],
                               input int n, input int partial_bits);
        logic [7:0] r;
        logic [5:0] a;
        int t0;
        t0 = txn_cnt;
        cs_assert();
        spi_byte(8'h0A, 8, r);
        spi_byte({2'($urandom), addr}, 8, r);
        a = addr;
        for (int i = 0; i < n; i++) begin
            spi_byte(d[i], 8, r);
            if (a == 6'h2D) m_power = d[i];
            else if (a == 6'h1F && d[i] == 8'h52) m_power = 8'h00;
            a = a + 6'd1;
        end
        if (partial_bits > 0) spi_byte(8'($urandom), partial_bits, r);
        cs_release();
        n_checks++;
        if (power !== m_power) $display("FAIL %s power_ctl: got %02h expected %02h", name, power, m_power);
        else n_pass++;
        n_checks++;
        if (txn_cnt - t0 !== 1) $display("FAIL %s txn_done count: got %0d expected 1", name, txn_cnt - t0);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        csn = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        ax = 8'h00;
        ay = 8'h00;
        az = 8'h00;
        wait_clk(6);
        rst = 1'b0;
        wait_clk(2);
        n_checks++;
        if (miso !== 1'b0) $display("FAIL reset miso: got %b expected 0", miso); else n_pass++;
        n_checks++;
        if (oe !== 1'b0) $display("FAIL reset oe: got %b expected 0", oe); else n_pass++;
        n_checks++;
        if (power !== 8'h00) $display("FAIL reset power_ctl: got %02h expected 00", power); else n_pass++;
        n_checks++;
        if (txn_done !== 1'b0) $display("FAIL reset txn_done: got %b expected 0", txn_done); else n_pass++;
        n_checks++;
        if (cmd_err !== 1'b0) $display("FAIL reset cmd_err: got %b expected 0", cmd_err); else n_pass++;
    endtask

    task automatic test_read_devid();
        csn = 1'b0;
        wait_clk(HALF);
        n_checks++;
        if (oe !== 1'b1) $display("FAIL devid oe while selected: got %b expected 1", oe); else n_pass++;
        csn = 1'b1;
        wait_clk(12);
        read_burst("devid", 6'h00, 3, 1'b0);
        n_checks++;
        if (oe !== 1'b0) $display("FAIL devid oe after release: got %b expected 0", oe); else n_pass++;
    endtask

    task automatic test_snapshot();
        ax = 8'h12;
        ay = 8'h34;
        az = 8'h56;
        read_burst("snapshot", 6'h08, 3, 1'b1);
    endtask

    task automatic test_write();
        logic [7:0] d [4];
        d = '{8'h02, 8'h00, 8'h00, 8'h00};
        write_burst("wr_power", 6'h2D, d, 1, 0);
        d = '{8'h52, 8'h00, 8'h00, 8'h00};
        write_burst("soft_reset", 6'h1F, d, 1, 0);
        d = '{8'h11, 8'h00, 8'h00, 8'h00};
        write_burst("soft_reset_bad_zero", 6'h1F, d, 1, 0);
        d = '{8'h5A, 8'h00, 8'h00, 8'h00};
        write_burst("wr_power2", 6'h2D, d, 1, 0);
        d = '{8'h11, 8'h00, 8'h00, 8'h00};
        write_burst("soft_reset_bad_key", 6'h1F, d, 1, 0);
        d = '{8'h77, 8'h00, 8'h00, 8'h00};
        write_burst("wr_readonly", 6'h08, d, 1, 0);
        read_burst("rd_power", 6'h2D, 1, 1'b0);
    endtask

    task automatic test_cmd_err();
        logic [7:0] cmd, r, acc;
        int t0, e0;
        do cmd = 8'($urandom); while (cmd == 8'h0A || cmd == 8'h0B);
        t0 = txn_cnt;
        e0 = err_cnt;
        acc = 8'h00;
        cs_assert();
        spi_byte(cmd, 8, r);
        spi_byte(8'h2D, 8, r);
        acc = acc | r;
        spi_byte(8'($urandom), 8, r);
        acc = acc | r;
        n_checks++;
        if (oe !== 1'b1) $display("FAIL cmd_err oe: got %b expected 1", oe); else n_pass++;
        cs_release();
        n_checks++;
        if (acc !== 8'h00) $display("FAIL cmd_err miso bits: got %02h expected 00", acc); else n_pass++;
        n_checks++;
        if (err_cnt - e0 !== 1) $display("FAIL cmd_err pulses: got %0d expected 1", err_cnt - e0); else n_pass++;
        n_checks++;
        if (txn_cnt - t0 !== 1) $display("FAIL cmd_err txn_done: got %0d expected 1", txn_cnt - t0); else n_pass++;
        n_checks++;
        if (power !== m_power) $display("FAIL cmd_err power_ctl: got %02h expected %02h", power, m_power); else n_pass++;
    endtask

    task automatic test_wrap_partial();
        logic [7:0] d [4];
        read_burst("wrap", 6'h3F, 2, 1'b0);
        d = '{~m_power, 8'h00, 8'h00, 8'h00};
        write_burst("partial", 6'h2D, d, 0, 4);
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d [4];
        logic [7:0] r;
        int t0;
        d = '{8'h0F, 8'h00, 8'h00, 8'h00};
        write_burst("pre_reset", 6'h2D, d, 1, 0);
        t0 = txn_cnt;
        cs_assert();
        spi_byte(8'h0B, 8, r);
        spi_byte(8'h00, 8, r);
        spi_byte(8'h00, 3, r);
        rst = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        m_power = 8'h00;
        wait_clk(2);
        n_checks++;
        if ({miso, oe, txn_done, cmd_err} !== 4'b0000)
            $display("FAIL midreset outputs: got %b expected 0000", {miso, oe, txn_done, cmd_err});
        else n_pass++;
        n_checks++;
        if (power !== 8'h00) $display("FAIL midreset power_ctl: got %02h expected 00", power); else n_pass++;
        spi_byte(8'hFF, 5, r);
        spi_byte(8'($urandom), 8, r);
        n_checks++;
        if (r !== 8'h00) $display("FAIL midreset miso after reset: got %02h expected 00", r); else n_pass++;
        n_checks++;
        if (oe !== 1'b0) $display("FAIL midreset oe after reset: got %b expected 0", oe); else n_pass++;
        cs_release();
        n_checks++;
        if (txn_cnt - t0 !== 0) $display("FAIL midreset txn_done: got %0d expected 0", txn_cnt - t0); else n_pass++;
        read_burst("post_reset", 6'h00, 3, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [7:0] r;
        int t0;
        t0 = txn_cnt;
        cs_assert();
        spi_byte(8'h0B, 8, r);
        spi_byte(8'h00, 8, r);
        spi_byte(8'h00, 8, r);
        n_checks++;
        if (r !== 8'hAD) $display("FAIL b2b first: got %02h expected AD", r); else n_pass++;
        wait_clk(4);
        csn = 1'b1;
        wait_clk(1);
        cs_assert();
        spi_byte(8'h0B, 8, r);
        spi_byte(8'h02, 8, r);
        spi_byte(8'h00, 8, r);
        n_checks++;
        if (r !== 8'hF2) $display("FAIL b2b second: got %02h expected F2", r); else n_pass++;
        cs_release();
        n_checks++;
        if (txn_cnt - t0 !== 2) $display("FAIL b2b txn_done: got %0d expected 2", txn_cnt - t0); else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0] d [4];
        logic [5:0] a;
        for (int it = 0; it < 12; it++) begin
            ax = 8'($urandom);
            ay = 8'($urandom);
            az = 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                case ($urandom_range(0, 4))
                    0:       a = 6'h3E;
                    1:       a = 6'h07;
                    2:       a = 6'h2C;
                    3:       a = 6'h00;
                    default: a = 6'($urandom);
                endcase
                read_burst("rand_rd", a, $urandom_range(1, 4), 1'b0);
            end else begin
                case ($urandom_range(0, 3))
                    0:       a = 6'h2D;
                    1:       a = 6'h1F;
                    2:       a = 6'h2C;
                    default: a = 6'($urandom);
                endcase
                for (int i = 0; i < 4; i++)
                    d[i] = ($urandom_range(0, 3) == 0) ? 8'h52 : 8'($urandom);
                write_burst("rand_wr", a, d, $urandom_range(1, 3), $urandom_range(0, 1) * 5);
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_devid();
        test_snapshot();
        test_write();
        test_cmd_err();
        test_wrap_partial();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
